wave_display_mc: RTL



---
 rtl/wave_display_mc_if.sv | 44 ++++
 rtl/wave_display_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_display_mc_if.sv
// Coordinate-in / sample-RAM / pixel-out bundle for wave_display_mc.
//   slave  : the renderer (consumes coordinates and RAM data, produces
//            RAM addresses and pixels).
//   master : its environment (timing generator, sample RAM, output mux).
// Signals:
//   in_valid/in_ready   coordinate handshake, with x, y, read_index, ch_en
//   read_address        {read_index, ch, col} to the sample RAM
//   read_value          RAM data, valid the cycle after read_address
//   out_valid/out_ready pixel handshake, with valid_pixel and r/g/b
interface wave_display_mc_if #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int COL_W    = 8,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = 1 + CH_W + COL_W;

    logic                in_valid;
    logic                in_ready;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic                read_index;
    logic [NUM_CH-1:0]   ch_en;
    logic [ADDR_W-1:0]   read_address;
    logic [SAMPLE_W-1:0] read_value;
    logic                out_valid;
    logic                out_ready;
    logic                valid_pixel;
    logic [7:0]          r;
    logic [7:0]          g;
    logic [7:0]          b;

    modport master (
        output in_valid, x, y, read_index, ch_en, read_value, out_ready,
        input  in_ready, read_address, out_valid, valid_pixel, r, g, b
    );

    modport slave (
        input  in_valid, x, y, read_index, ch_en, read_value, out_ready,
        output in_ready, read_address, out_valid, valid_pixel, r, g, b
    );
endinterface

// File: rtl/wave_display_mc.sv
// Multi-channel waveform renderer. For every accepted pixel coordinate it
// decides whether the pixel lies on the line segment joining the previous and
// current column sample of any enabled channel, and emits one registered RGB
// pixel. Samples come from a 1-cycle-latency RAM and are cached per column so
// that neighbouring pixels of the same column need no RAM traffic.
// Ports:
//   clk  clock
//   rst  synchronous active-low reset
//   bus  wave_display_mc_if.slave (coordinate in, RAM port, pixel out)
module wave_display_mc #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int COL_W    = 8,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int X_MIN    = 258,
    parameter int OFFSET   = 32,
    parameter logic [NUM_CH*24-1:0] CH_COLOR = {24'hFFFFFF, 24'h00FF00}
) (
    input  logic                  clk,
    input  logic                  rst,
    wave_display_mc_if.slave      bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int COLS   = 1 << COL_W;
    localparam int ADDR_W = 1 + CH_W + COL_W;
    localparam int X_END  = X_MIN + 2 * COLS;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_FETCH_PREV = 2'd1;
    localparam logic [1:0] S_FETCH_CUR  = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Screen-space height of a sample: halved, then lifted by OFFSET (wraps).
    function automatic logic [SAMPLE_W-1:0] adj(input logic [SAMPLE_W-1:0] s);
        return {1'b0, s[SAMPLE_W-1:1]} + SAMPLE_W'(OFFSET);
    endfunction

    // Inclusive span test that does not care which endpoint is larger.
    function automatic logic in_span(input logic [SAMPLE_W-1:0] t,
                                     input logic [SAMPLE_W-1:0] a,
                                     input logic [SAMPLE_W-1:0] b);
        return (a <= b) ? (t >= a && t <= b) : (t >= b && t <= a);
    endfunction

    // ---------------------------------------------------------------- state
    logic [1:0]          state_q, state_d;
    logic [CH_W-1:0]     cnt_q, cnt_d;          // channel of the address being issued
    logic                rd_pend_q, rd_pend_d;  // a read was issued last cycle
    logic                rd_prev_q, rd_prev_d;  // ... and it targets prev_c
    logic [CH_W-1:0]     rd_ch_q, rd_ch_d;      // ... for this channel
    logic                copy_prev_q, copy_prev_d; // column 0: prev mirrors cur
    logic [ADDR_W-1:0]   read_address_q, read_address_d;
    logic [COL_W-1:0]    req_col_q, req_col_d;
    logic                req_idx_q, req_idx_d;
    logic [SAMPLE_W-1:0] req_ty_q, req_ty_d;
    logic [NUM_CH-1:0]   req_en_q, req_en_d;
    logic                cache_valid_q, cache_valid_d;
    logic [COL_W-1:0]    cached_col_q, cached_col_d;
    logic                cached_idx_q, cached_idx_d;
    logic [SAMPLE_W-1:0] cur_q [NUM_CH];
    logic [SAMPLE_W-1:0] cur_d [NUM_CH];
    logic [SAMPLE_W-1:0] prev_q [NUM_CH];
    logic [SAMPLE_W-1:0] prev_d [NUM_CH];
    logic                out_valid_q, out_valid_d;
    logic                valid_pixel_q, valid_pixel_d;
    logic [23:0]         rgb_q, rgb_d;

    // ------------------------------------------------------- input decode
    logic [X_W-1:0]      x_off;
    logic [COL_W-1:0]    in_col;
    logic [SAMPLE_W-1:0] in_ty;
    logic                in_region;
    logic                cache_hit;
    logic                seq_miss;
    logic                in_ready;
    logic                accept;
    logic                unused_bits;

    assign x_off     = bus.x - X_W'(X_MIN);
    assign in_col    = x_off[COL_W:1];
    assign in_ty     = bus.y[SAMPLE_W:1];
    assign in_region = (int'(bus.x) >= X_MIN) && (int'(bus.x) < X_END) && !bus.y[Y_W-1];
    assign cache_hit = cache_valid_q && (in_col == cached_col_q) && (bus.read_index == cached_idx_q);
    // Column 0 never counts as "next" so that a wrap from COLS-1 is a jump.
    assign seq_miss  = cache_valid_q && (bus.read_index == cached_idx_q) &&
                       (in_col != '0) && (in_col == cached_col_q + COL_W'(1));
    assign in_ready  = rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign unused_bits = ^{bus.y, x_off};

    // ------------------------------------------- RAM capture into the cache
    // Cache contents including the read landing this cycle, so the pixel
    // computed in DONE already sees the final sample.
    logic [SAMPLE_W-1:0] cap_cur [NUM_CH];
    logic [SAMPLE_W-1:0] cap_prev [NUM_CH];

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cap_cur  = cur_q;
        cap_prev = prev_q;
        if (rd_pend_q) begin
            if (rd_prev_q) begin
                cap_prev[rd_ch_q] = bus.read_value;
            end else begin
                cap_cur[rd_ch_q] = bus.read_value;
                if (copy_prev_q) begin
                    cap_prev[rd_ch_q] = bus.read_value;
                end
            end
        end
    end

    // --------------------------------------------------- pixel colouring
    // Direct pixels are coloured from the live inputs; fetched pixels from
    // the values captured at accept.
    logic [SAMPLE_W-1:0] eval_ty;
    logic [NUM_CH-1:0]   eval_en;
    logic                eval_region;
    logic [23:0]         pix_rgb;

    always_comb begin
        eval_ty     = (state_q == S_DONE) ? req_ty_q : in_ty;
        eval_en     = (state_q == S_DONE) ? req_en_q : bus.ch_en;
        eval_region = (state_q == S_DONE) ? 1'b1 : in_region;
        pix_rgb     = '0;
        // Descending scan: the lowest hitting channel is written last and wins.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (eval_region && eval_en[c] &&
                in_span(eval_ty, adj(cap_prev[c]), adj(cap_cur[c]))) begin
                pix_rgb = CH_COLOR[24*c +: 24];
            end
        end
    end

    // ------------------------------------------------------ control FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_pend_d      = 1'b0;
        rd_prev_d      = rd_prev_q;
        rd_ch_d        = rd_ch_q;
        copy_prev_d    = copy_prev_q;
        read_address_d = read_address_q;
        req_col_d      = req_col_q;
        req_idx_d      = req_idx_q;
        req_ty_d       = req_ty_q;
        req_en_d       = req_en_q;
        cache_valid_d  = cache_valid_q;
        cached_col_d   = cached_col_q;
        cached_idx_d   = cached_idx_q;
        cur_d          = cap_cur;
        prev_d         = cap_prev;
        out_valid_d    = out_valid_q && !bus.out_ready;
        valid_pixel_d  = valid_pixel_q;
        rgb_d          = rgb_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_col_d = in_col;
                    req_idx_d = bus.read_index;
                    req_ty_d  = in_ty;
                    req_en_d  = bus.ch_en;
                    if (!in_region || cache_hit) begin
                        out_valid_d   = 1'b1;
                        valid_pixel_d = in_region;
                        rgb_d         = pix_rgb;
                    end else begin
                        cache_valid_d = 1'b0;
                        cnt_d         = '0;
                        copy_prev_d   = 1'b0;
                        if (seq_miss) begin
                            prev_d         = cur_q;
                            state_d        = S_FETCH_CUR;
                            read_address_d = {bus.read_index, {CH_W{1'b0}}, in_col};
                        end else if (in_col == '0) begin
                            copy_prev_d    = 1'b1;
                            state_d        = S_FETCH_CUR;
                            read_address_d = {bus.read_index, {CH_W{1'b0}}, in_col};
                        end else begin
                            state_d        = S_FETCH_PREV;
                            read_address_d = {bus.read_index, {CH_W{1'b0}}, in_col - COL_W'(1)};
                        end
                    end
                end
            end

            S_FETCH_PREV, S_FETCH_CUR: begin
                // The address on the bus this cycle returns data next cycle.
                rd_pend_d = 1'b1;
                rd_prev_d = (state_q == S_FETCH_PREV);
                rd_ch_d   = cnt_q;
                if (cnt_q == LAST_CH) begin
                    cnt_d = '0;
                    if (state_q == S_FETCH_PREV) begin
                        state_d        = S_FETCH_CUR;
                        read_address_d = {req_idx_q, {CH_W{1'b0}}, req_col_q};
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d          = cnt_q + CH_W'(1);
                    read_address_d = {req_idx_q, cnt_q + CH_W'(1),
                                      (state_q == S_FETCH_PREV) ? req_col_q - COL_W'(1) : req_col_q};
                end
            end

            S_DONE: begin
                cache_valid_d = 1'b1;
                cached_col_d  = req_col_q;
                cached_idx_d  = req_idx_q;
                copy_prev_d   = 1'b0;
                out_valid_d   = 1'b1;
                valid_pixel_d = 1'b1;
                rgb_d         = pix_rgb;
                state_d       = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rd_pend_q      <= 1'b0;
            rd_prev_q      <= 1'b0;
            rd_ch_q        <= '0;
            copy_prev_q    <= 1'b0;
            read_address_q <= '0;
            req_col_q      <= '0;
            req_idx_q      <= 1'b0;
            req_ty_q       <= '0;
            req_en_q       <= '0;
            cache_valid_q  <= 1'b0;
            cached_col_q   <= '0;
            cached_idx_q   <= 1'b0;
            // NOTE: the sample cache is only NUM_CH pairs of flops, so it is
            // cleared too; correctness rests on cache_valid_q alone.
            for (int c = 0; c < NUM_CH; c++) begin
                cur_q[c]  <= '0;
                prev_q[c] <= '0;
            end
            out_valid_q    <= 1'b0;
            valid_pixel_q  <= 1'b0;
            rgb_q          <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_pend_q      <= rd_pend_d;
            rd_prev_q      <= rd_prev_d;
            rd_ch_q        <= rd_ch_d;
            copy_prev_q    <= copy_prev_d;
            read_address_q <= read_address_d;
            req_col_q      <= req_col_d;
            req_idx_q      <= req_idx_d;
            req_ty_q       <= req_ty_d;
            req_en_q       <= req_en_d;
            cache_valid_q  <= cache_valid_d;
            cached_col_q   <= cached_col_d;
            cached_idx_q   <= cached_idx_d;
            cur_q          <= cur_d;
            prev_q         <= prev_d;
            out_valid_q    <= out_valid_d;
            valid_pixel_q  <= valid_pixel_d;
            rgb_q          <= rgb_d;
        end
    end

    // ---------------------------------------------------------- outputs
    assign bus.in_ready     = in_ready;
    assign bus.read_address = read_address_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.valid_pixel  = valid_pixel_q;
    assign bus.r            = rgb_q[23:16];
    assign bus.g            = rgb_q[15:8];
    assign bus.b            = rgb_q[7:0];
endmodule
